// File: rtl/wbm_pkg.sv
// Shared definitions for the Wishbone command master: bus widths, FSM encoding
// and the beat address helpers used by the master.
package wbm_pkg;

    localparam int WB_ADDR_W  = 64;
    localparam int WB_DATA_W  = 64;
    localparam int WB_SEL_W   = 8;
    localparam int WB_TIMER_W = 16;

    localparam logic [WB_ADDR_W-1:0] WB_BEAT_BYTES = 64'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_GAP  = 2'b10
    } wbm_state_e;

    // Beats are always whole 64-bit words, so the byte offset is dropped.
    function automatic logic [WB_ADDR_W-1:0] wb_align(input logic [WB_ADDR_W-1:0] addr);
        return {addr[WB_ADDR_W-1:3], 3'b000};
    endfunction

    function automatic logic [WB_ADDR_W-1:0] wb_next_addr(input logic [WB_ADDR_W-1:0] addr);
        return addr + WB_BEAT_BYTES;
    endfunction

endpackage

// File: rtl/wbm_timer.sv
// Ack timeout counter: counts enabled cycles since the last clear and flags the
// cycle on which the LIMIT-th enabled cycle is being counted.
module wbm_timer
    import wbm_pkg::*;
#(
    parameter int WIDTH = WB_TIMER_W,
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/wbm_cmd_master.sv
// Command-to-Wishbone burst master: turns one accepted command into 1..2^LEN_BITS
// single-beat Wishbone cycles, one response pulse per beat, with an ack timeout.
module wbm_cmd_master
    import wbm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_BITS       = 4
) (
    input  logic                 sys_clock_i,
    input  logic                 sys_reset_i,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [WB_ADDR_W-1:0] cmd_addr_i,
    input  logic [WB_DATA_W-1:0] cmd_data_i,
    input  logic [WB_SEL_W-1:0]  cmd_sel_i,
    input  logic [LEN_BITS-1:0]  cmd_len_i,

    output logic                 rsp_valid_o,
    output logic [WB_DATA_W-1:0] rsp_data_o,
    output logic                 rsp_last_o,
    output logic                 rsp_err_o,

    output logic                 wbm_cycle_o,
    output logic                 wbm_strobe_o,
    output logic                 wbm_we_o,
    output logic [WB_ADDR_W-1:0] wbm_addr_o,
    output logic [WB_DATA_W-1:0] wbm_data_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    input  logic [WB_DATA_W-1:0] wbm_data_i,
    input  logic                 wbm_ack_i
);

    wbm_state_e           state_q, state_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS-1:0]  beat_q, beat_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [WB_ADDR_W-1:0] addr_q, addr_d;
    logic [WB_DATA_W-1:0] wdata_q, wdata_d;
    logic [WB_SEL_W-1:0]  sel_q, sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 rsp_err_q, rsp_err_d;

    logic in_bus;
    logic timer_clear;
    logic timer_enable;
    logic timeout_hit;
    logic last_beat;

    assign in_bus       = (state_q == ST_BUS);
    assign timer_clear  = !in_bus;
    assign timer_enable = in_bus && !wbm_ack_i;
    assign last_beat    = (beat_q == len_q);

    wbm_timer #(
        .WIDTH (WB_TIMER_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (sys_clock_i),
        .rst     (sys_reset_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout_hit)
    );

    // The write data register doubles as the fill latch; it is forced to zero for
    // reads and whenever the master is idle.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = ST_BUS;
                    len_d   = cmd_len_i;
                    beat_d  = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cmd_we_i;
                    addr_d  = wb_align(cmd_addr_i);
                    wdata_d = cmd_we_i ? cmd_data_i : '0;
                    sel_d   = cmd_sel_i;
                end
            end

            ST_BUS: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (wbm_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = we_q ? '0 : wbm_data_i;
                    stb_d       = 1'b0;
                    if (last_beat) begin
                        rsp_last_d = 1'b1;
                        cyc_d      = 1'b0;
                        we_d       = 1'b0;
                        wdata_d    = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_BITS'(1);
                        addr_d  = wb_next_addr(addr_q);
                        state_d = ST_GAP;
                    end
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    wdata_d     = '0;
                    state_d     = ST_IDLE;
                end
            end

            ST_GAP: begin
                stb_d   = 1'b1;
                state_d = ST_BUS;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_last_o   = rsp_last_q;
    assign rsp_err_o    = rsp_err_q;

    assign wbm_cycle_o  = cyc_q;
    assign wbm_strobe_o = stb_q;
    assign wbm_we_o     = we_q;
    assign wbm_addr_o   = addr_q;
    assign wbm_data_o   = wdata_q;
    assign wbm_sel_o    = sel_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Directed bench for wbm_cmd_master against a small registered-ack memory slave
// with a programmable ack delay.
module tb_wbm_cmd_master;

    localparam int LEN_BITS = 4;
    localparam int TIMEOUT  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [63:0]         cmd_addr;
    logic [63:0]         cmd_data;
    logic [7:0]          cmd_sel;
    logic [LEN_BITS-1:0] cmd_len;
    logic                rsp_valid;
    logic [63:0]         rsp_data;
    logic                rsp_last;
    logic                rsp_err;
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [63:0]         wb_addr;
    logic [63:0]         wb_wdata;
    logic [7:0]          wb_sel;
    logic [63:0]         slv_rdata;
    logic                slv_ack;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    wbm_cmd_master #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .LEN_BITS       (LEN_BITS)
    ) dut (
        .sys_clock_i  (clk),
        .sys_reset_i  (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .cmd_sel_i    (cmd_sel),
        .cmd_len_i    (cmd_len),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_last_o   (rsp_last),
        .rsp_err_o    (rsp_err),
        .wbm_cycle_o  (wb_cyc),
        .wbm_strobe_o (wb_stb),
        .wbm_we_o     (wb_we),
        .wbm_addr_o   (wb_addr),
        .wbm_data_o   (wb_wdata),
        .wbm_sel_o    (wb_sel),
        .wbm_data_i   (slv_rdata),
        .wbm_ack_i    (slv_ack)
    );

    // Memory slave: acks once strobe has been seen for ack_delay+1 edges and keeps
    // acking while strobe stays high, so a late duplicate ack lands in GAP/IDLE.
    logic [63:0] mem [0:127];
    logic        ack_en;
    int          ack_delay;
    int          wcnt;
    logic [6:0]  slv_idx;

    assign slv_idx = wb_addr[9:3];

    function automatic logic [63:0] preset(input int i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'hA000_0000 + 32'(i);
        lo = 32'h5000_0000 + 32'(i);
        return (i == 16) ? 64'h0246_8ACE_1357_9BDF : {hi, lo};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] sel);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            slv_ack   <= 1'b0;
            slv_rdata <= '0;
            wcnt      <= 0;
            for (int i = 0; i < 128; i++) mem[i] <= preset(i);
        end else if (wb_cyc && wb_stb) begin
            wcnt <= wcnt + 1;
            if (ack_en && wcnt >= ack_delay) begin
                slv_ack   <= 1'b1;
                slv_rdata <= mem[slv_idx];
                if (wb_we) mem[slv_idx] <= merge(mem[slv_idx], wb_wdata, wb_sel);
            end else begin
                slv_ack <= 1'b0;
            end
        end else begin
            wcnt    <= 0;
            slv_ack <= 1'b0;
        end
    end

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
        int          cyc_n;
        logic        bus_cyc;
        logic        bus_stb;
        logic        ready;
    } rsp_rec_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  sel;
    } bus_rec_t;

    rsp_rec_t rsp_q[$];
    bus_rec_t bus_q[$];
    int       viol = 0;
    logic     stb_prev = 1'b0;

    // Monitor: one record per response pulse and per strobe rising edge.
    always @(negedge clk) begin
        if (rsp_valid)
            rsp_q.push_back('{rsp_data, rsp_last, rsp_err, cycle_cnt, wb_cyc, wb_stb, cmd_ready});
        if (!rsp_valid && (rsp_last || rsp_err)) viol++;
        if (wb_cyc && wb_stb && !stb_prev)
            bus_q.push_back('{wb_addr, wb_we, wb_wdata, wb_sel});
        stb_prev = wb_stb;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic issueCmd(input logic we, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] sel, input logic [LEN_BITS-1:0] len,
                            output int acc_cyc);
        rsp_q.delete();
        bus_q.delete();
        @(negedge clk);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_sel   = sel;
        cmd_len   = len;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_cyc   = cycle_cnt;
    endtask

    task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] sel, input logic [LEN_BITS-1:0] len,
                                 output int acc_cyc);
        int n;
        issueCmd(we, addr, data, sel, len, acc_cyc);
        for (n = 0; n < 400; n++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        checkOutput("cmd completes", 64'(n < 400), 64'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  sel;
        logic [63:0] exp_addr;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] burst_exp[4];
    int          acc;
    int          nlast;
    logic        found;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 64'h80, 64'h0,                   8'hFF, 64'h80, 64'h0246_8ACE_1357_9BDF};
        vecs[1] = '{1'b1, 64'h13, 64'h1122_3344_5566_7788, 8'h0F, 64'h10, 64'h0};
        vecs[2] = '{1'b0, 64'h10, 64'h0,                   8'hFF, 64'h10, 64'hA000_0002_5566_7788};
        vecs[3] = '{1'b1, 64'h28, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'h28, 64'h0};
        vecs[4] = '{1'b0, 64'h2F, 64'h0,                   8'hFF, 64'h28, 64'hDEAD_BEEF_5000_0005};
        vecs[5] = '{1'b0, 64'h07, 64'h0,                   8'hFF, 64'h00, 64'hA000_0000_5000_0000};
        burst_exp = '{64'hA000_0000_5000_0000, 64'hA000_0001_5000_0001,
                      64'hA000_0002_5566_7788, 64'hA000_0003_5000_0003};

        // Commands are presented throughout reset and must be ignored.
        rst = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 64'h80;
        cmd_data = '0; cmd_sel = 8'hFF; cmd_len = '0;
        ack_en = 1'b1; ack_delay = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in reset cycle", 64'(wb_cyc), 64'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset ready", 64'(cmd_ready), 64'd1);
        checkOutput("reset bus ctl", 64'({wb_cyc, wb_stb, wb_we}), 64'd0);
        checkOutput("reset addr", wb_addr, 64'd0);
        checkOutput("reset wdata", wb_wdata, 64'd0);
        checkOutput("reset rsp", 64'({rsp_valid, rsp_last, rsp_err}), 64'd0);
        checkOutput("reset rsp data", rsp_data, 64'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, '0, acc);
            checkOutput($sformatf("vec%0d nrsp", i), 64'(rsp_q.size()), 64'd1);
            checkOutput($sformatf("vec%0d nbus", i), 64'(bus_q.size()), 64'd1);
            if (bus_q.size() > 0) begin
                checkOutput($sformatf("vec%0d addr", i), bus_q[0].addr, vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d we", i), 64'(bus_q[0].we), 64'(vecs[i].we));
                checkOutput($sformatf("vec%0d wdata", i), bus_q[0].wdata,
                            vecs[i].we ? vecs[i].data : 64'h0);
                checkOutput($sformatf("vec%0d sel", i), 64'(bus_q[0].sel), 64'(vecs[i].sel));
            end
            if (rsp_q.size() > 0) begin
                checkOutput($sformatf("vec%0d rdata", i), rsp_q[0].data, vecs[i].exp_rdata);
                checkOutput($sformatf("vec%0d last/err", i),
                            64'({rsp_q[0].last, rsp_q[0].err}), 64'b10);
                checkOutput($sformatf("vec%0d latency", i), 64'(rsp_q[0].cyc_n - acc), 64'd2);
                checkOutput($sformatf("vec%0d bus idle", i),
                            64'({rsp_q[0].bus_cyc, rsp_q[0].bus_stb, rsp_q[0].ready}), 64'b001);
            end
        end

        // Four-beat read burst: addresses, last flag only on the final beat, 3-cycle spacing.
        applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF, 4'd3, acc);
        checkOutput("burst nrsp", 64'(rsp_q.size()), 64'd4);
        checkOutput("burst nbus", 64'(bus_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < rsp_q.size() && k < bus_q.size(); k++) begin
            checkOutput($sformatf("burst addr%0d", k), bus_q[k].addr, 64'(8 * k));
            checkOutput($sformatf("burst data%0d", k), rsp_q[k].data, burst_exp[k]);
            checkOutput($sformatf("burst last%0d", k), 64'({rsp_q[k].last, rsp_q[k].err}),
                        (k == 3) ? 64'b10 : 64'b00);
            if (k > 0)
                checkOutput($sformatf("burst gap%0d", k),
                            64'(rsp_q[k].cyc_n - rsp_q[k-1].cyc_n), 64'd3);
        end

        // Two-beat write fill, then read both words back.
        applyStimulus(1'b1, 64'h40, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, 4'd1, acc);
        checkOutput("fill nbus", 64'(bus_q.size()), 64'd2);
        for (int k = 0; k < 2 && k < bus_q.size(); k++) begin
            checkOutput($sformatf("fill wdata%0d", k), bus_q[k].wdata, 64'h0F1E_2D3C_4B5A_6978);
            checkOutput($sformatf("fill addr%0d", k), bus_q[k].addr, 64'(64'h40 + 8 * k));
        end
        applyStimulus(1'b0, 64'h40, 64'h0, 8'hFF, 4'd1, acc);
        checkOutput("fill rb nrsp", 64'(rsp_q.size()), 64'd2);
        if (rsp_q.size() == 2) begin
            checkOutput("fill rb0", rsp_q[0].data, 64'h0F1E_2D3C_4B5A_6978);
            checkOutput("fill rb1", rsp_q[1].data, 64'h0F1E_2D3C_4B5A_6978);
        end

        // Sixteen-beat burst that wraps from the top of the address space to zero.
        applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'hFF, 4'd15, acc);
        checkOutput("wrap nrsp", 64'(rsp_q.size()), 64'd16);
        checkOutput("wrap nbus", 64'(bus_q.size()), 64'd16);
        if (bus_q.size() >= 2) begin
            checkOutput("wrap addr0", bus_q[0].addr, 64'hFFFF_FFFF_FFFF_FFF8);
            checkOutput("wrap addr1", bus_q[1].addr, 64'h0);
        end
        if (rsp_q.size() == 16) begin
            nlast = 0;
            foreach (rsp_q[k]) nlast += int'(rsp_q[k].last);
            checkOutput("wrap nlast", 64'(nlast), 64'd1);
            checkOutput("wrap last15", 64'(rsp_q[15].last), 64'd1);
            checkOutput("wrap data0", rsp_q[0].data, 64'hA000_007F_5000_007F);
            checkOutput("wrap data1", rsp_q[1].data, 64'hA000_0000_5000_0000);
        end

        // Ack never arrives: abort after TIMEOUT bus cycles with an error response.
        ack_en = 1'b0;
        applyStimulus(1'b0, 64'h100, 64'h0, 8'hFF, 4'd3, acc);
        checkOutput("tmo nrsp", 64'(rsp_q.size()), 64'd1);
        checkOutput("tmo nbus", 64'(bus_q.size()), 64'd1);
        if (rsp_q.size() > 0) begin
            checkOutput("tmo last/err", 64'({rsp_q[0].last, rsp_q[0].err}), 64'b11);
            checkOutput("tmo data", rsp_q[0].data, 64'h0);
            checkOutput("tmo latency", 64'(rsp_q[0].cyc_n - acc), 64'(TIMEOUT));
            checkOutput("tmo bus/ready", 64'({rsp_q[0].bus_cyc, rsp_q[0].bus_stb, rsp_q[0].ready}),
                        64'b001);
        end
        ack_en = 1'b1;

        // Ack on the same edge as the timeout: ack wins.
        ack_delay = TIMEOUT - 2;
        applyStimulus(1'b0, 64'h80, 64'h0, 8'hFF, '0, acc);
        checkOutput("tie nrsp", 64'(rsp_q.size()), 64'd1);
        if (rsp_q.size() > 0) begin
            checkOutput("tie last/err", 64'({rsp_q[0].last, rsp_q[0].err}), 64'b10);
            checkOutput("tie data", rsp_q[0].data, 64'h0246_8ACE_1357_9BDF);
            checkOutput("tie latency", 64'(rsp_q[0].cyc_n - acc), 64'(TIMEOUT));
        end

        // Ack one cycle too late: timeout, and the late ack in IDLE is ignored.
        ack_delay = TIMEOUT - 1;
        applyStimulus(1'b0, 64'h80, 64'h0, 8'hFF, '0, acc);
        checkOutput("late nrsp", 64'(rsp_q.size()), 64'd1);
        if (rsp_q.size() > 0)
            checkOutput("late last/err", 64'({rsp_q[0].last, rsp_q[0].err}), 64'b11);
        ack_delay = 0;

        // Reset during the GAP of a four-beat burst drops the transfer silently.
        issueCmd(1'b0, 64'h0, 64'h0, 8'hFF, 4'd3, acc);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wb_cyc && !wb_stb) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst gap found", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst gap bus", 64'({wb_cyc, wb_stb, wb_we}), 64'd0);
        checkOutput("rst gap addr", wb_addr, 64'd0);
        checkOutput("rst gap rsp", 64'({rsp_valid, rsp_last, rsp_err}), 64'd0);
        rst = 1'b0;
        #1;
        rsp_q.delete();
        @(negedge clk);
        checkOutput("rst gap ready", 64'(cmd_ready), 64'd1);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("rst gap no rsp", 64'(rsp_q.size()), 64'd0);
        applyStimulus(1'b0, 64'h80, 64'h0, 8'hFF, '0, acc);
        checkOutput("post rst nrsp", 64'(rsp_q.size()), 64'd1);
        if (rsp_q.size() > 0)
            checkOutput("post rst data", rsp_q[0].data, 64'h0246_8ACE_1357_9BDF);

        checkOutput("last/err only with valid", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbm_cmd_master.md
WBM_CMD_MASTER -- requirements
Module: wbm_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max BUS-state cycles without ack before abort (range 2..65535).
REQ-002 SHALL have parameter LEN_BITS, default 4: width of burst-length field.
REQ-003 sys_clock_i  in  1  system clock; single clock domain, all logic on rising edge.
REQ-004 sys_reset_i  in  1  system reset, synchronous, active-high.
REQ-005 cmd_valid_i  in  1  command request; cmd_ready_o  out  1  command accepted when both high at an edge.
REQ-006 cmd_we_i  in  1  1=write, 0=read; cmd_addr_i  in  64  byte address; cmd_data_i  in  64  write data; cmd_sel_i  in  8  byte select.
REQ-007 cmd_len_i  in  LEN_BITS  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-008 rsp_valid_o  out  1  one-cycle pulse per completed beat; rsp_data_o  out  64  read data; rsp_last_o  out  1  final beat or abort; rsp_err_o  out  1  timeout abort.
REQ-009 wbm_cycle_o, wbm_strobe_o, wbm_we_o  out  1 each; wbm_addr_o  out  64; wbm_data_o  out  64; wbm_sel_o  out  8; all registered.
REQ-010 wbm_data_i  in  64  slave read data; wbm_ack_i  in  1  slave acknowledge.

Function
REQ-011 States: IDLE, BUS, GAP; encoding 2 bits, from shared package.
REQ-012 cmd_ready_o SHALL be 1 exactly when state is IDLE; commands are ignored while sys_reset_i is high.
REQ-013 On accept: latch we, sel, data, len; latch address with bits [2:0] forced to 0; next edge enter BUS with cycle=strobe=1.
REQ-014 In BUS, wbm_ack_i sampled high SHALL complete the beat: capture wbm_data_i (reads) or 0 (writes) into rsp_data_o, pulse rsp_valid_o the following cycle.
REQ-015 After a non-final beat: strobe=0, cycle held 1, enter GAP for exactly one cycle; address += 8 (mod 2^64 wrap); return to BUS with strobe=1.
REQ-016 wbm_ack_i SHALL be ignored in GAP and IDLE (late/duplicate acks from registered slaves).
REQ-017 Final beat (len+1 beats done): cycle=strobe=we=0, rsp_last_o=1 with that beat's rsp_valid_o, return to IDLE.
REQ-018 Write bursts SHALL drive the latched cmd_data_i on every beat (fill); wbm_data_o=0 during reads and IDLE.
REQ-019 Steady-state beat period SHALL be 3 cycles against a slave with 1-cycle registered ack.
REQ-020 Timeout counter (16 bit) cleared on each BUS entry, increments per BUS cycle without ack; at TIMEOUT_CYCLES abort: cycle=strobe=0, rsp_valid_o=rsp_last_o=rsp_err_o=1, rsp_data_o=0, to IDLE; remaining beats discarded.
REQ-021 Ack and timeout on the same edge: ack wins, no error.
REQ-022 rsp_err_o, rsp_last_o SHALL be 0 whenever rsp_valid_o is 0; no response backpressure.

Reset
REQ-023 Reset SHALL force IDLE; all wbm_* outputs, rsp_* outputs, counters to 0; cmd_ready_o 1 the cycle after reset deasserts.
REQ-024 Reset mid-burst SHALL drop the transfer immediately with no response pulse.

Structure
REQ-025 Shared package wbm_pkg SHALL hold state encoding, WB_ADDR_W=64, WB_DATA_W=64, WB_SEL_W=8.
REQ-026 One sub-module wbm_timer (clear/enable/expired, width 16) for the timeout; rest in wbm_cmd_master.

Verification (against mem_harness slave, memory preset)
REQ-027 Single read addr 0x80, sel 0xFF, mem[0x10]=02468ACE13579BDF -> one rsp_valid_o, data 02468ACE13579BDF, last=1, err=0.
REQ-028 Write addr 0x13, data 0x1122334455667788, sel 0x0F, len 0 -> bus addr 0x10, lower 4 bytes updated; readback matches.
REQ-029 Read burst len 3 from 0x0 -> 4 responses, addrs 0x0/0x8/0x10/0x18, last only on 4th, 3-cycle spacing, no duplicate beats.
REQ-030 Ack tied 0, TIMEOUT_CYCLES=8 -> abort after 8 BUS cycles: rsp_err_o=1, rsp_last_o=1, cycle/strobe 0, cmd_ready_o 1 next cycle.
REQ-031 Burst len 15 from 0xFFFFFFFFFFFFFFF8 -> second beat addr 0x0 (wrap).
REQ-032 Reset asserted in GAP of a 4-beat burst -> outputs 0 next edge, no further rsp_valid_o, new command accepted after release.
